// File: rtl/cpu_pkg.sv
// Shared datapath definitions: word width, MDR read-FSM state encoding and timeout default.
package cpu_pkg;

    localparam int WORD_W      = 32;
    localparam int MDR_TIMEOUT = 15;
    localparam int MDR_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } mdr_state_e;

endpackage

// File: rtl/mdr_unit_if.sv
// Bus/memory handshake bundle for the MDR stage; slave = MDR, master = control unit + memory.
interface mdr_unit_if;
    import cpu_pkg::*;

    logic [WORD_W-1:0] bus_in;
    logic              mdr_in;
    logic              read;
    logic              mem_req;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] mdr_out;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output bus_in, mdr_in, read, mem_ack, mem_data,
        input  mem_req, mdr_out, busy, done, err
    );

    modport slave (
        input  bus_in, mdr_in, read, mem_ack, mem_data,
        output mem_req, mdr_out, busy, done, err
    );

endinterface

// File: rtl/mux2_1.sv
// 32-bit 2:1 multiplexer shared by datapath registers; sel_i=1 picks b_i.
module mux2_1 (
    input  logic        sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            assign y_o[gi] = sel_i ? b_i[gi] : a_i[gi];
        end
    endgenerate

endmodule

// File: rtl/reg32_en.sv
// 32-bit register with load enable and asynchronous active-high clear.
module reg32_en (
    input  logic        clk,
    input  logic        clr,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] data_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mdr_unit.sv
// Memory Data Register with bus load and request/acknowledge memory read.
// Optional read timeout with sticky err flag: define MDR_TIMEOUT_EN.
module mdr_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W  = WORD_W,
    parameter int TIMEOUT = MDR_TIMEOUT
) (
    input  logic clk,
    input  logic clr,
    mdr_unit_if.slave bus
);

    mdr_state_e        state_q;
    logic              mem_req_q;
    logic              busy_q;
    logic              done_q;
    logic              read_phase;
    logic              load_en;
    logic [DATA_W-1:0] mux_y;
    logic [DATA_W-1:0] mdr_q;

    // The mux select follows the FSM: memory data is only ever taken while waiting on ack.
    assign read_phase = (state_q == WAIT);
    assign load_en    = ((state_q == IDLE) && bus.mdr_in) ||
                        ((state_q == WAIT) && bus.mem_ack);

    mux2_1 u_mux (
        .sel_i (read_phase),
        .a_i   (bus.bus_in),
        .b_i   (bus.mem_data),
        .y_o   (mux_y)
    );

    reg32_en u_mdr (
        .clk  (clk),
        .clr  (clr),
        .en_i (load_en),
        .d_i  (mux_y),
        .q_o  (mdr_q)
    );

`ifdef MDR_TIMEOUT_EN
    localparam logic [MDR_CNT_W-1:0] TIMEOUT_LAST = MDR_CNT_W'(TIMEOUT - 1);
    logic [MDR_CNT_W-1:0] cnt_q;
    logic                 err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.read) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
`ifdef MDR_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    // An ack arriving on the timeout cycle still completes the read.
                    if (bus.mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req = mem_req_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.mdr_out = mdr_q;
`ifdef MDR_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_unit.sv
// Directed self-checking bench for mdr_unit (timeout scenario only when MDR_TIMEOUT_EN is defined).
module tb_mdr_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mdr_unit_if bus_if ();

    mdr_unit dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b1;
        bus_if.bus_in = '0; bus_if.mdr_in = 1'b0; bus_if.read = 1'b0;
        bus_if.mem_ack = 1'b0; bus_if.mem_data = '0;
        tick();
        checks++;
        if ({bus_if.mdr_out, bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.err} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got mdr=%h req=%b busy=%b done=%b err=%b exp all 0",
                     bus_if.mdr_out, bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.err);
        end
        clr = 1'b0;
        tick();
        $display("tb: reset -> mdr=%h", bus_if.mdr_out);
    endtask

    task automatic test_bus_load;
        bus_if.bus_in = 32'hDEADBEEF; bus_if.mdr_in = 1'b1;
        tick();
        bus_if.mdr_in = 1'b0; bus_if.bus_in = 32'h0;
        checks++;
        if (bus_if.mdr_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bus_load_data got=%h exp=deadbeef", bus_if.mdr_out);
        end
        checks++;
        if ({bus_if.busy, bus_if.mem_req, bus_if.done} !== 3'b000) begin
            failures++; $display("FAIL bus_load_flags got busy/req/done=%b%b%b exp=000",
                                 bus_if.busy, bus_if.mem_req, bus_if.done);
        end
        tick();
        checks++;
        if (bus_if.mdr_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bus_load_hold got=%h exp=deadbeef", bus_if.mdr_out);
        end
        $display("tb: bus load -> mdr=%h", bus_if.mdr_out);
    endtask

    task automatic test_mem_read;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        checks++;
        if ({bus_if.mem_req, bus_if.busy, bus_if.done} !== 3'b110) begin
            failures++; $display("FAIL read_req_cycle got req/busy/done=%b%b%b exp=110",
                                 bus_if.mem_req, bus_if.busy, bus_if.done);
        end
        tick();
        checks++;
        if (bus_if.mem_req !== 1'b1) begin
            failures++; $display("FAIL read_wait1_req got=%b exp=1", bus_if.mem_req);
        end
        tick();
        checks++;
        if (bus_if.mem_req !== 1'b1) begin
            failures++; $display("FAIL read_wait2_req got=%b exp=1", bus_if.mem_req);
        end
        bus_if.mem_ack = 1'b1; bus_if.mem_data = 32'h12345678;
        checks++;
        if (bus_if.mdr_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL read_before_ack got=%h exp=deadbeef", bus_if.mdr_out);
        end
        tick();
        bus_if.mem_ack = 1'b0; bus_if.mem_data = 32'h0;
        checks++;
        if (bus_if.mdr_out !== 32'h12345678) begin
            failures++; $display("FAIL read_data got=%h exp=12345678", bus_if.mdr_out);
        end
        checks++;
        if ({bus_if.done, bus_if.mem_req, bus_if.busy} !== 3'b100) begin
            failures++; $display("FAIL read_done got done/req/busy=%b%b%b exp=100",
                                 bus_if.done, bus_if.mem_req, bus_if.busy);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.mdr_out !== 32'h12345678) begin
            failures++; $display("FAIL read_done_pulse got done=%b mdr=%h exp done=0 mdr=12345678",
                                 bus_if.done, bus_if.mdr_out);
        end
        $display("tb: mem read -> mdr=%h", bus_if.mdr_out);
    endtask

    task automatic test_simultaneous;
        bus_if.bus_in = 32'h1; bus_if.mem_data = 32'h2;
        bus_if.mdr_in = 1'b1; bus_if.read = 1'b1;
        tick();
        bus_if.mdr_in = 1'b0; bus_if.read = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'h1 || bus_if.busy !== 1'b1) begin
            failures++; $display("FAIL simul_bus_first got mdr=%h busy=%b exp mdr=00000001 busy=1",
                                 bus_if.mdr_out, bus_if.busy);
        end
        tick();
        bus_if.mem_ack = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'h2 || bus_if.done !== 1'b1) begin
            failures++; $display("FAIL simul_mem_second got mdr=%h done=%b exp mdr=00000002 done=1",
                                 bus_if.mdr_out, bus_if.done);
        end
        tick();
        $display("tb: simultaneous load+read -> mdr=%h", bus_if.mdr_out);
    endtask

    task automatic test_ignored_inputs;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        bus_if.mdr_in = 1'b1; bus_if.bus_in = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (bus_if.mdr_out !== 32'h2) begin
            failures++; $display("FAIL ignore_mdr_in_req got=%h exp=00000002", bus_if.mdr_out);
        end
        tick();
        checks++;
        if (bus_if.mdr_out !== 32'h2) begin
            failures++; $display("FAIL ignore_mdr_in_wait got=%h exp=00000002", bus_if.mdr_out);
        end
        bus_if.mdr_in = 1'b0;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_data = 32'hA5A5A5A5;
        tick();
        bus_if.mem_ack = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'hA5A5A5A5 || bus_if.done !== 1'b1) begin
            failures++; $display("FAIL ignore_read_busy_ack got mdr=%h done=%b exp mdr=a5a5a5a5 done=1",
                                 bus_if.mdr_out, bus_if.done);
        end
        tick();
        checks++;
        if (bus_if.mem_req !== 1'b0 || bus_if.busy !== 1'b0) begin
            failures++; $display("FAIL ignore_read_no_queue got req=%b busy=%b exp 0 0",
                                 bus_if.mem_req, bus_if.busy);
        end
        bus_if.mem_ack = 1'b1; bus_if.mem_data = 32'h0BADF00D;
        tick();
        tick();
        bus_if.mem_ack = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'hA5A5A5A5 || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            failures++; $display("FAIL ignore_stray_ack got mdr=%h done=%b busy=%b exp mdr=a5a5a5a5 done=0 busy=0",
                                 bus_if.mdr_out, bus_if.done, bus_if.busy);
        end
        $display("tb: ignored inputs -> mdr=%h", bus_if.mdr_out);
    endtask

    task automatic test_reset_mid_read;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        tick();
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({bus_if.mdr_out, bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.err} !== 36'h0) begin
            failures++; $display("FAIL reset_mid_read got mdr=%h req=%b busy=%b done=%b err=%b exp all 0",
                                 bus_if.mdr_out, bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.err);
        end
        #1 clr = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_data = 32'h55;
        tick();
        tick();
        bus_if.mem_ack = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'h0 || bus_if.done !== 1'b0 || bus_if.mem_req !== 1'b0) begin
            failures++; $display("FAIL reset_late_ack got mdr=%h done=%b req=%b exp 0 0 0",
                                 bus_if.mdr_out, bus_if.done, bus_if.mem_req);
        end
        $display("tb: reset mid-read -> mdr=%h", bus_if.mdr_out);
    endtask

`ifdef MDR_TIMEOUT_EN
    task automatic test_timeout;
        bit req_held;
        bus_if.bus_in = 32'hCAFEF00D; bus_if.mdr_in = 1'b1;
        tick();
        bus_if.mdr_in = 1'b0;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        req_held = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (bus_if.mem_req !== 1'b1) req_held = 1'b0;
            tick();
        end
        checks++;
        if (req_held !== 1'b1 || bus_if.mem_req !== 1'b1) begin
            failures++; $display("FAIL timeout_req_held got held=%b req=%b exp 1 1", req_held, bus_if.mem_req);
        end
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.err} !== 4'b0001 ||
            bus_if.mdr_out !== 32'hCAFEF00D) begin
            failures++; $display("FAIL timeout_abort got req/busy/done/err=%b%b%b%b mdr=%h exp 0001 cafef00d",
                                 bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.err, bus_if.mdr_out);
        end
        tick(); tick();
        checks++;
        if (bus_if.err !== 1'b1) begin
            failures++; $display("FAIL timeout_err_sticky got=%b exp=1", bus_if.err);
        end
        // Ack lands on the 15th WAIT cycle: data wins over the timeout.
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        repeat (15) tick();
        bus_if.mem_ack = 1'b1; bus_if.mem_data = 32'h99;
        tick();
        bus_if.mem_ack = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'h99 || bus_if.done !== 1'b1 || bus_if.err !== 1'b0) begin
            failures++; $display("FAIL timeout_ack_wins got mdr=%h done=%b err=%b exp 00000099 1 0",
                                 bus_if.mdr_out, bus_if.done, bus_if.err);
        end
        tick();
        $display("tb: timeout -> mdr=%h err=%b", bus_if.mdr_out, bus_if.err);
    endtask
`else
    task automatic test_unbounded_wait;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        repeat (20) tick();
        checks++;
        if ({bus_if.mem_req, bus_if.busy, bus_if.err, bus_if.done} !== 4'b1100) begin
            failures++; $display("FAIL unbounded_wait got req/busy/err/done=%b%b%b%b exp 1100",
                                 bus_if.mem_req, bus_if.busy, bus_if.err, bus_if.done);
        end
        bus_if.mem_ack = 1'b1; bus_if.mem_data = 32'h77;
        tick();
        bus_if.mem_ack = 1'b0;
        checks++;
        if (bus_if.mdr_out !== 32'h77 || bus_if.done !== 1'b1 || bus_if.err !== 1'b0) begin
            failures++; $display("FAIL unbounded_late_ack got mdr=%h done=%b err=%b exp 00000077 1 0",
                                 bus_if.mdr_out, bus_if.done, bus_if.err);
        end
        tick();
        $display("tb: unbounded wait -> mdr=%h", bus_if.mdr_out);
    endtask
`endif

    initial begin
        test_reset();
        test_bus_load();
        test_mem_read();
        test_simultaneous();
        test_ignored_inputs();
        test_reset_mid_read();
`ifdef MDR_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
